// File: rtl/evo_eval_pkg.sv
// Shared definitions for the evolved-circuit evaluator.
//   eval_state_t : evaluator FSM states
//   XOR3_TT      : truth table of a 3-input XOR (default grading target)
//   nv(n)        : number of input vectors for an n-input circuit
package evo_eval_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    NEXT,
    DONE
  } eval_state_t;

  localparam logic [7:0] XOR3_TT = 8'h96;

  function automatic int unsigned nv(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/evo_circuit_evaluator_if.sv
// Controller-side bus of the evaluator: start request and graded results.
//   start         : request a full evaluation (controller -> evaluator)
//   busy, done    : run status; done is a one-cycle pulse
//   score         : number of passing vectors, 0..NV
//   fail_mask     : bit i set when vector i failed
//   unstable_mask : bit i set when vector i's samples disagreed
interface evo_circuit_evaluator_if #(
  parameter int unsigned N_IN = 3
);
  localparam int unsigned NV = 32'd1 << N_IN;

  logic          start;
  logic          busy;
  logic          done;
  logic [N_IN:0] score;
  logic [NV-1:0] fail_mask;
  logic [NV-1:0] unstable_mask;

  modport master (
    output start,
    input  busy, done, score, fail_mask, unstable_mask
  );

  modport slave (
    input  start,
    output busy, done, score, fail_mask, unstable_mask
  );
endinterface

// File: rtl/evo_circuit_evaluator_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk, rst_n : clock, async active-low reset (flops clear to 0)
//   d          : asynchronous input
//   q          : synchronized output, two cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/evo_circuit_evaluator.sv
// Sweeps every input vector of a combinational circuit under test, waits a
// settle window, samples its (synchronized) output for several cycles and
// grades it against a truth table.
//   clk, rst_n : clock, async active-low reset
//   bus        : controller bus (start in; busy/done/score/masks out)
//   dut_in     : vector driven to the circuit under test
//   dut_out    : circuit output, asynchronous to clk
module evo_circuit_evaluator
  import evo_eval_pkg::*;
#(
  parameter int unsigned N_IN          = 3,
  parameter              EXPECTED      = XOR3_TT,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SAMPLES       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  evo_circuit_evaluator_if.slave  bus,
  output logic [N_IN-1:0]         dut_in,
  input  logic                    dut_out
);
  localparam int unsigned NV      = nv(N_IN);
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [NV-1:0] TT    = EXPECTED;

  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 3");
  end
  if (SAMPLES < 1) begin : g_bad_samples
    $error("SAMPLES must be >= 1");
  end
  if ($bits(EXPECTED) != NV) begin : g_bad_tt
    $error("EXPECTED must be 2**N_IN bits wide");
  end

  eval_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [N_IN-1:0]  v;
  logic             s_out;
  logic             first_sample;
  logic             vec_fail;
  logic             vec_unstable;
  logic [N_IN:0]    score;
  logic [NV-1:0]    fail_mask;
  logic [NV-1:0]    unstable_mask;
  logic             busy;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_out),
    .q     (s_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETTLE;
      SETTLE:  if (cnt == '0) state_nxt = SAMPLE;
      SAMPLE:  if (cnt == '0) state_nxt = NEXT;
      NEXT:    state_nxt = (v == N_IN'(NV - 1)) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      v             <= '0;
      first_sample  <= 1'b0;
      vec_fail      <= 1'b0;
      vec_unstable  <= 1'b0;
      score         <= '0;
      fail_mask     <= '0;
      unstable_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            score         <= '0;
            fail_mask     <= '0;
            unstable_mask <= '0;
            v             <= '0;
            cnt           <= CNT_W'(SETTLE_CYCLES - 1);
            vec_fail      <= 1'b0;
            vec_unstable  <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt == '0) cnt <= CNT_W'(SAMPLES - 1);
          else           cnt <= cnt - CNT_W'(1);
        end
        SAMPLE: begin
          // The first sampled cycle of a vector is the stability reference.
          if (cnt == CNT_W'(SAMPLES - 1)) first_sample <= s_out;
          else if (s_out != first_sample) vec_unstable <= 1'b1;
          if (s_out != TT[v]) vec_fail <= 1'b1;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        NEXT: begin
          if (vec_fail || vec_unstable) begin
            fail_mask[v]     <= 1'b1;
            unstable_mask[v] <= vec_unstable;
          end else begin
            score <= score + (N_IN + 1)'(1);
          end
          if (v != N_IN'(NV - 1)) begin
            v            <= v + N_IN'(1);
            cnt          <= CNT_W'(SETTLE_CYCLES - 1);
            vec_fail     <= 1'b0;
            vec_unstable <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy              = (state == SETTLE) || (state == SAMPLE) || (state == NEXT);
  assign dut_in            = busy ? v : '0;
  assign bus.busy          = busy;
  assign bus.done          = (state == DONE);
  assign bus.score         = score;
  assign bus.fail_mask     = fail_mask;
  assign bus.unstable_mask = unstable_mask;

endmodule

// File: tb/tb_evo_circuit_evaluator.sv
// Self-checking bench for evo_circuit_evaluator: drives several behavioural
// circuit models and grades the evaluator's results against a scoreboard.
module tb_evo_circuit_evaluator;
  localparam int unsigned N_IN = 3;
  localparam int unsigned LAT  = 72;

  typedef struct {
    int         score;
    logic [7:0] fail;
    logic [7:0] unst;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            lag_q = 1'b0;
  int              mode = 0;
  int              cyc = 0;
  int              cyc5 = 0;
  int              done_cnt = 0;
  int              total = 0;
  int              bad = 0;
  exp_t            sb[$];

  evo_circuit_evaluator_if #(.N_IN(N_IN)) bus ();

  evo_circuit_evaluator #(
    .N_IN          (N_IN),
    .EXPECTED      (8'h96),
    .SETTLE_CYCLES (4),
    .SAMPLES       (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .dut_in  (dut_in),
    .dut_out (dut_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    lag_q <= ^dut_in;
    cyc5  <= (dut_in == 3'd5) ? cyc5 + 1 : 0;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  // Behavioural circuits under test: 0 ideal XOR3, 1 stuck-0, 2 stuck-1,
  // 3 inverted, 4 XOR3 with one-cycle lag, 5 XOR3 toggling on vector 5.
  always_comb begin
    case (mode)
      1:       dut_out = 1'b0;
      2:       dut_out = 1'b1;
      3:       dut_out = ~^dut_in;
      4:       dut_out = lag_q;
      5:       dut_out = (^dut_in) ^ ((dut_in == 3'd5 && cyc5 >= 3) ? cyc5[0] : 1'b0);
      default: dut_out = ^dut_in;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input int m);
    exp_t e;
    logic b;
    e.fail = '0;
    e.unst = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      b = ^(i[2:0]);
      case (m)
        1: if (b)  e.fail[i] = 1'b1;
        2: if (!b) e.fail[i] = 1'b1;
        3: e.fail[i] = 1'b1;
        5: if (i == 5) begin e.fail[i] = 1'b1; e.unst[i] = 1'b1; end
        default: ;
      endcase
    end
    e.score = 8 - $countones(e.fail);
    return e;
  endfunction

  task automatic run_eval(input int m, input bit poke);
    exp_t e;
    int   c0;
    int   t;
    int   d0;
    mode = m;
    d0   = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    c0 = cyc + 1;
    sb.push_back(model(m));
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("dut_in_after_start", dut_in, 0);
    t = 0;
    while (!bus.done && t < 200) begin
      @(negedge clk);
      t++;
      if (poke && t == 30) bus.start = 1'b1;
      else if (poke && t == 31) bus.start = 1'b0;
    end
    check("done_seen", bus.done, 1);
    if (bus.done && sb.size() > 0) begin
      e = sb.pop_front();
      check("latency", cyc - c0, LAT);
      check("score", bus.score, e.score);
      check("fail_mask", bus.fail_mask, e.fail);
      check("unstable_mask", bus.unstable_mask, e.unst);
      check("busy_at_done", bus.busy, 0);
      check("dut_in_at_done", dut_in, 0);
      if (poke) begin
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("single_done", done_cnt - d0, 1);
        check("idle_after_poke", bus.busy, 0);
        check("score_held", bus.score, e.score);
        check("fail_held", bus.fail_mask, e.fail);
        check("unst_held", bus.unstable_mask, e.unst);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    bus.start = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_score", bus.score, 0);
    check("rst_fail", bus.fail_mask, 0);
    check("rst_unst", bus.unstable_mask, 0);
    check("rst_dut_in", dut_in, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_eval(0, 1'b0);
    run_eval(1, 1'b0);
    run_eval(2, 1'b0);
    run_eval(3, 1'b0);
    run_eval(4, 1'b0);
    run_eval(5, 1'b0);
    run_eval(0, 1'b1);

    // Reset in the middle of vector 3 of a stuck-at-0 run.
    mode = 1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while (dut_in != 3'd3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reach_v3", dut_in, 3);
    check("partial_fail", bus.fail_mask, 8'h06);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_score", bus.score, 0);
    check("mid_rst_fail", bus.fail_mask, 0);
    check("mid_rst_unst", bus.unstable_mask, 0);
    check("mid_rst_dut_in", dut_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no_restart", bus.busy, 0);
    run_eval(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/evo_circuit_evaluator.md
# evo_circuit_evaluator

Sequential test harness that drives an evolved combinational circuit and grades it against a truth table. It sweeps every input vector, waits a settle window, and samples the circuit output over several cycles. It reports a correctness score plus per-vector fail and instability masks. It sits between the evolution controller, which issues start and reads results, and the LCELL-based circuit under test.

## Interface
- `N_IN`, 3: circuit-under-test input width; vector count `NV = 2**N_IN`.
- `EXPECTED`, `8'h96`: truth table, `NV` bits; bit `i` is the required output for input `i` (default is 3-input XOR).
- `SETTLE_CYCLES`, 4: cycles after a vector is applied before sampling starts; must be ≥3.
- `SAMPLES`, 4: consecutive sampled cycles per vector; must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a full evaluation; accepted only in IDLE.
- `dut_in`  out  `N_IN`  vector driven to the circuit under test.
- `dut_out`  in  1  circuit output; asynchronous, with no timing relation to `clk`.
- `busy`  out  1  high from the cycle after start acceptance until the done cycle, inclusive of neither endpoint.
- `done`  out  1  one-cycle pulse when results are final.
- `score`  out  `N_IN+1`  count of vectors passing, 0..`NV`.
- `fail_mask`  out  `NV`  bit `i` set when vector `i` failed.
- `unstable_mask`  out  `NV`  bit `i` set when samples of vector `i` disagreed among themselves.

## Operation
- `dut_out` passes through a 2-flop synchronizer; all sampling uses the synchronized value `s_out`.
- FSM states are IDLE, SETTLE, SAMPLE, NEXT, DONE.
  - IDLE → SETTLE on `start`. On this transition: `score`, `fail_mask`, `unstable_mask` clear; vector index `v` is set to 0; `busy` is set.
  - SETTLE holds for `SETTLE_CYCLES` cycles (down-counter), then moves to SAMPLE.
  - SAMPLE holds for `SAMPLES` cycles. Each cycle compares `s_out` to `EXPECTED[v]` and to the first sample of the vector.
  - Any mismatch to the expected value marks the vector as failed. Any sample that differs from the first marks it unstable. An unstable vector is always also failed.
  - NEXT lasts one cycle. It commits the per-vector result: sets `fail_mask[v]`/`unstable_mask[v]` or increments `score`.
  - From NEXT: if `v == NV-1`, go to DONE; otherwise `v` increments and the FSM returns to SETTLE.
  - DONE lasts one cycle: `done`=1, `busy`=0, then → IDLE.
- `dut_in` equals `v` in SETTLE/SAMPLE/NEXT. It updates at entry to SETTLE and is 0 in IDLE/DONE.
- `start` is ignored in every state except IDLE, including DONE.
- Results hold stable from DONE until the next accepted start.
- `score` width `N_IN+1` holds `NV` without overflow. Increments saturate by construction, since there is at most one per vector.

## Timing
- Reset values: `dut_in`=0, `busy`=0, `done`=0, `score`=0, both masks=0, synchronizer=0, state IDLE.
- Start accepted at edge k: `busy`=1 and `dut_in`=0 are valid after edge k.
- Per vector: `SETTLE_CYCLES + SAMPLES + 1` cycles.
- `done` rises `NV*(SETTLE_CYCLES+SAMPLES+1)` cycles after the accepting edge. With defaults this is 72.
- DUT output lag tolerated: up to `SETTLE_CYCLES-2` cycles (synchronizer consumes 2).
- Reset asserted mid-run: all outputs return to reset values immediately (async). Partial results are discarded. The next run must be a full restart.
- `start` held high continuously: the next run begins the cycle after DONE (IDLE sees start).

## Structure
- Shared package `evo_eval_pkg`:
  - state enum `eval_state_t`;
  - constant `XOR3_TT = 8'h96`;
  - function `nv(n)` returning `2**n`.
- Sub-module `sync_2ff` (1-bit, async active-low reset to 0) for `dut_out`.
- Parameter legality is checked with elaboration-time assertions (`SETTLE_CYCLES>=3`, `SAMPLES>=1`, `$bits(EXPECTED)==NV`).

## Test plan
- Ideal XOR3 model, defaults, start pulse → `done` at cycle 72, `score`=8, `fail_mask`=0, `unstable_mask`=0.
- DUT stuck-at-0 → `score`=4, `fail_mask`=`8'h96`, `unstable_mask`=0; stuck-at-1 → `score`=4, `fail_mask`=`8'h69`.
- Inverted XOR3 → `score`=0, `fail_mask`=`8'hFF`; XOR3 model with 1-cycle output lag → `score`=8.
- Model toggles output during the SAMPLE window of vector 5 only → `score`=7, `fail_mask`=`8'h20`, `unstable_mask`=`8'h20`.
- `start` pulsed while `busy`, and again during DONE → ignored, exactly one `done` pulse, results unchanged.
- `rst_n` low during vector 3 → all outputs 0 asynchronously; a fresh start then completes with `score`=8 at cycle 72.
